vrf_load_store_ctrl: RTL and testbench

- Initiator side of the vector register file port: moves one 512-bit vector (32 lanes x 16-bit signed) between vector data memory and one of the four architectural vector registers A1..A4.
- Accepts LOAD/STORE requests from the processor control unit.
- Sequences memory access and drives the register file one-hot write1..4 / read1..4 strobes, dataIn, and the dataOut capture.
- Sits between the control unit, the register file and the data memory.

---
 rtl/vrf_pkg.sv | 33 +++
 rtl/vrf_strobe_decode.sv | 28 ++
 rtl/vrf_load_store_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_vrf_load_store_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
//==============================================================================
// Module      : vrf_pkg
// Description : Shared lane/vector types, op and FSM state enums for the VRF port.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package vrf_pkg;

  localparam int NUM_LANES = 32;
  localparam int LANE_W    = 16;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef lane_t vector_t [0:NUM_LANES-1];

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_RF_WR  = 3'd2,
    ST_RF_RD  = 3'd3,
    ST_RF_CAP = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_FIN    = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vrf_strobe_decode.sv
//==============================================================================
// Module      : vrf_strobe_decode
// Description : Register index plus enables to one-hot write/read strobes.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module vrf_strobe_decode
  import vrf_pkg::*;
(
  input  logic [1:0] i_reg,
  input  logic       i_wr_en,
  input  logic       i_rd_en,
  output logic [3:0] o_write,
  output logic [3:0] o_read
);

  logic [3:0] w_onehot;

  assign w_onehot = 4'b0001 << i_reg;

  // Write has priority so a read and a write can never share a cycle.
  assign o_write = i_wr_en ? w_onehot : 4'b0000;
  assign o_read  = (i_rd_en && !i_wr_en) ? w_onehot : 4'b0000;

endmodule

`default_nettype wire

// File: rtl/vrf_load_store_ctrl.sv
//==============================================================================
// Module      : vrf_load_store_ctrl
// Description : Sequences one 512-bit vector move between data memory and A1..A4.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module vrf_load_store_ctrl
  import vrf_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_op,
  input  logic [1:0]        i_req_reg,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_mem_rd_en,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output vector_t           o_mem_wdata,
  input  vector_t           i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_rf_write1,
  output logic              o_rf_write2,
  output logic              o_rf_write3,
  output logic              o_rf_write4,
  output logic              o_rf_read1,
  output logic              o_rf_read2,
  output logic              o_rf_read3,
  output logic              o_rf_read4,
  output vector_t           o_rf_dataIn,
  input  vector_t           i_rf_dataOut,
  output logic              o_done,
  output logic              o_error
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  op_e               r_op;
  logic [1:0]        r_reg;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic              r_done;
  logic              r_error;
  vector_t           r_rf_data_in;
  vector_t           r_mem_wdata;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [3:0]        w_write;
  logic [3:0]        w_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_LOAD;
      r_reg       <= 2'd0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_rf_data_in[i] <= '0;
        r_mem_wdata[i]  <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_op        <= op_e'(i_req_op);
            r_reg       <= i_req_reg;
            r_addr      <= i_req_addr;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            if (i_req_op == OP_STORE) begin
              r_state <= ST_RF_RD;
            end else begin
              r_state     <= ST_MEM_RD;
              r_mem_rd_en <= 1'b1;
            end
          end
        end
        // Ack is tested before the timeout so a same-cycle ack still succeeds.
        ST_MEM_RD: begin
          if (i_mem_ack) begin
            r_rf_data_in <= i_mem_rdata;
            r_mem_rd_en  <= 1'b0;
            r_cnt        <= '0;
            r_state      <= ST_RF_WR;
          end else if (r_cnt == c_cnt_last) begin
            r_mem_rd_en <= 1'b0;
            r_error     <= 1'b1;
            r_req_ready <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RF_WR: begin
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end
        ST_RF_RD: begin
          r_state <= ST_RF_CAP;
        end
        // Register file output is registered: data for the read is valid now.
        ST_RF_CAP: begin
          r_mem_wdata <= i_rf_dataOut;
          r_mem_wr_en <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_MEM_WR;
        end
        ST_MEM_WR: begin
          if (i_mem_ack) begin
            r_mem_wr_en <= 1'b0;
            r_done      <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_FIN;
          end else if (r_cnt == c_cnt_last) begin
            r_mem_wr_en <= 1'b0;
            r_error     <= 1'b1;
            r_req_ready <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIN: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_mem_rd_en <= 1'b0;
          r_mem_wr_en <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_wr_en = (r_state == ST_RF_WR) && (r_op == OP_LOAD);
  assign w_rd_en = (r_state == ST_RF_RD) && (r_op == OP_STORE);

  vrf_strobe_decode u_strobe_decode (
    .i_reg   (r_reg),
    .i_wr_en (w_wr_en),
    .i_rd_en (w_rd_en),
    .o_write (w_write),
    .o_read  (w_read)
  );

  assign o_rf_write1 = w_write[0];
  assign o_rf_write2 = w_write[1];
  assign o_rf_write3 = w_write[2];
  assign o_rf_write4 = w_write[3];
  assign o_rf_read1  = w_read[0];
  assign o_rf_read2  = w_read[1];
  assign o_rf_read3  = w_read[2];
  assign o_rf_read4  = w_read[3];

  assign o_req_ready = r_req_ready;
  assign o_mem_rd_en = r_mem_rd_en;
  assign o_mem_wr_en = r_mem_wr_en;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rf_dataIn = r_rf_data_in;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_vrf_load_store_ctrl.sv
//==============================================================================
// Module      : tb_vrf_load_store_ctrl
// Description : Randomized bench with memory/register-file images and a reference model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_vrf_load_store_ctrl;
  import vrf_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_op = 1'b0;
  logic [1:0]        req_reg = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  vector_t           mem_wdata, mem_rdata, rf_dataIn, rf_dataOut;
  logic              mem_ack = 1'b0;
  logic              rf_write1, rf_write2, rf_write3, rf_write4;
  logic              rf_read1, rf_read2, rf_read3, rf_read4;
  logic              done, error;

  vrf_load_store_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_reg(req_reg), .i_req_addr(req_addr),
    .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_rf_write1(rf_write1), .o_rf_write2(rf_write2), .o_rf_write3(rf_write3), .o_rf_write4(rf_write4),
    .o_rf_read1(rf_read1), .o_rf_read2(rf_read2), .o_rf_read3(rf_read3), .o_rf_read4(rf_read4),
    .o_rf_dataIn(rf_dataIn), .i_rf_dataOut(rf_dataOut),
    .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  // env_* are what the DUT actually did to the environment; ref_* is the model.
  logic [511:0] env_mem [0:1023];
  logic [511:0] ref_mem [0:1023];
  logic [511:0] env_rf  [0:3];
  logic [511:0] ref_rf  [0:3];

  int   n_vec = 0;
  int   n_err = 0;
  bit   prev_end = 1'b0;
  logic [15:0] cap_wr_l0, cap_wr_l31, cap_wd31;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack(input vector_t v);
    logic [511:0] r;
    for (int i = 0; i < NUM_LANES; i++) r[16*i +: 16] = v[i];
    return r;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < NUM_LANES; i++) begin
      mem_rdata[i]  = 16'($urandom);
      rf_dataOut[i] = 16'($urandom);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    scramble_inputs();
  endtask

  task automatic do_txn(input logic op, input logic [1:0] rg, input logic [ADDR_W-1:0] ad,
                        input int k, input bit noack, input bit hold);
    int e = -1, done_n = -1, err_n = -1, nwr = 0, nrd = 0, viol = 0, addr_bad = 0;
    int ndone = 0, nerr = 0, waitc = 0, exp_e;
    logic [3:0] wr, rd, wr_idx = 4'd0, rd_idx = 4'd0;
    logic [1:0] rd_sel = 2'd0;
    bit rd_pend = 1'b0;
    req_valid = 1'b1; req_op = op; req_reg = rg; req_addr = ad;
    while (!req_ready) begin
      if (waitc == 20) begin
        check("accept_ready", req_ready, 1);
        req_valid = 1'b0;
        return;
      end
      next_cycle();
      waitc++;
      if (prev_end && waitc == 1) check("ready_after_done", req_ready, 1);
    end
    prev_end = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      next_cycle();
      if (!hold) req_valid = 1'b0;
      if (rd_pend) begin
        for (int i = 0; i < NUM_LANES; i++) rf_dataOut[i] = env_rf[rd_sel][16*i +: 16];
        rd_pend = 1'b0;
      end
      wr = {rf_write4, rf_write3, rf_write2, rf_write1};
      rd = {rf_read4, rf_read3, rf_read2, rf_read1};
      if ($countones({wr, rd}) > 1) viol++;
      if (wr != 4'd0) begin
        nwr++; wr_idx = wr;
        env_rf[idx_of(wr)] = pack(rf_dataIn);
        cap_wr_l0 = rf_dataIn[0]; cap_wr_l31 = rf_dataIn[31];
      end
      if (rd != 4'd0) begin
        nrd++; rd_idx = rd; rd_pend = 1'b1; rd_sel = idx_of(rd);
      end
      if (mem_rd_en || mem_wr_en) begin
        if (e < 0) e = n;
        if (mem_addr !== ad) addr_bad++;
        if (!noack && n == e + k) begin
          mem_ack = 1'b1;
          if (mem_rd_en)
            for (int i = 0; i < NUM_LANES; i++) mem_rdata[i] = env_mem[ad][16*i +: 16];
          if (mem_wr_en) begin
            env_mem[ad] = pack(mem_wdata);
            cap_wd31 = mem_wdata[31];
          end
        end
      end
      if (done)  begin ndone++; if (done_n < 0) done_n = n; end
      if (error) begin nerr++;  if (err_n < 0)  err_n = n;  end
      if (done_n >= 0 || err_n >= 0) break;
    end
    if (done_n < 0 && err_n < 0) check("completion", done | error, 1);
    exp_e = (op == OP_LOAD) ? 1 : 3;
    check("enable_rise", e, exp_e);
    if (!noack) begin
      check("done_cycle", done_n, (op == OP_LOAD) ? k + 3 : k + 4);
      check("error_count", nerr, 0);
      check("ready_in_done", req_ready, 0);
      if (op == OP_LOAD) ref_rf[rg] = ref_mem[ad];
      else               ref_mem[ad] = ref_rf[rg];
      prev_end = 1'b1;
    end else begin
      check("error_cycle", err_n, exp_e + TIMEOUT);
      check("done_count", ndone, 0);
      next_cycle();
      check("ready_after_error", req_ready, 1);
    end
    check("wr_strobes", nwr, (op == OP_LOAD && !noack) ? 1 : 0);
    if (nwr > 0) check("wr_index", wr_idx, 4'b0001 << rg);
    check("rd_strobes", nrd, (op == OP_STORE) ? 1 : 0);
    if (nrd > 0) check("rd_index", rd_idx, 4'b0001 << rg);
    check("strobe_overlap", viol, 0);
    check("mem_addr", addr_bad, 0);
    check("rf_contents", env_rf[rg], ref_rf[rg]);
    check("mem_contents", env_mem[ad], ref_mem[ad]);
  endtask

  initial begin
    logic [511:0] v;
    int bad, w;
    scramble_inputs();
    for (int a = 0; a < 1024; a++) begin v = rand_vec(); env_mem[a] = v; ref_mem[a] = v; end
    for (int r = 0; r < 4; r++) begin v = rand_vec(); env_rf[r] = v; ref_rf[r] = v; end

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_strobes", {rf_write4, rf_write3, rf_write2, rf_write1, rf_read4, rf_read3, rf_read2, rf_read1}, 0);
    check("rst_done_error", {done, error}, 0);
    check("rst_mem_en", {mem_rd_en, mem_wr_en}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wdata", pack(mem_wdata), 0);
    check("rst_dataIn", pack(rf_dataIn), 0);
    rst = 1'b0;

    // LOAD A3 from address 5, lane i = 3i - 40.
    for (int i = 0; i < NUM_LANES; i++) v[16*i +: 16] = 16'(i * 3 - 40);
    env_mem[5] = v; ref_mem[5] = v;
    do_txn(OP_LOAD, 2'd2, 10'h005, 2, 1'b0, 1'b0);
    check("load_lane0", cap_wr_l0, 16'hFFD8);
    check("load_lane31", cap_wr_l31, 16'h0035);

    // STORE A1, lane i = -i.
    for (int i = 0; i < NUM_LANES; i++) v[16*i +: 16] = 16'(-i);
    env_rf[0] = v; ref_rf[0] = v;
    do_txn(OP_STORE, 2'd0, 10'h3A7, 1, 1'b0, 1'b0);
    check("store_lane31", cap_wd31, 16'hFFE1);

    do_txn(OP_LOAD,  2'd1, 10'h011, 0, 1'b1, 1'b0);
    do_txn(OP_LOAD,  2'd3, 10'h012, TIMEOUT - 1, 1'b0, 1'b0);
    do_txn(OP_STORE, 2'd2, 10'h013, 0, 1'b1, 1'b0);

    // Back-to-back with req_valid held across both requests.
    do_txn(OP_STORE, 2'd3, 10'h020, 2, 1'b0, 1'b1);
    do_txn(OP_LOAD,  2'd3, 10'h021, 3, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++)
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10'($urandom_range(0, 15)),
             $urandom_range(1, 6), ($urandom_range(0, 9) == 0), 1'b0);

    // Reset while in MEM_WR, followed by a late ack.
    req_valid = 1'b1; req_op = OP_STORE; req_reg = 2'd1; req_addr = 10'h030;
    for (w = 0; w < 20 && !req_ready; w++) next_cycle();
    next_cycle();
    req_valid = 1'b0;
    for (w = 0; w < 10 && !mem_wr_en; w++) next_cycle();
    check("wr_en_before_reset", mem_wr_en, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mem_ack = 1'b1;
    check("rst_mid_wr_en", mem_wr_en, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_wdata", pack(mem_wdata), 0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      bad += int'(done) + int'(error) + int'(mem_rd_en) + int'(mem_wr_en)
           + $countones({rf_write4, rf_write3, rf_write2, rf_write1, rf_read4, rf_read3, rf_read2, rf_read1});
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_mem", env_mem[10'h030], ref_mem[10'h030]);
    prev_end = 1'b0;

    do_txn(OP_LOAD, 2'd1, 10'h030, 2, 1'b0, 1'b0);
    req_valid = 1'b0;
    repeat (2) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
